warp_issue_arbiter: RTL

//  Parametrised issue stage between per-warp instruction buffers and execution units.
//  - Each cycle, picks one eligible warp using round-robin or greedy-then-round-robin.
//  - Loads the picked instruction into a registered issue slot with valid/ready handshake.
//  - Pulses the scoreboard / instruction-buffer pop interface for the picked warp.
//  - Maintains issue and stall performance counters.

---
 rtl/warp_issue_arbiter.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/warp_issue_arbiter.sv
// -----------------------------------------------------------------------------
// warp_issue_arbiter
//   Issue stage between the per-warp instruction buffers and the execution
//   units. Each cycle one eligible warp is picked (round-robin, or greedy
//   with a burst cap followed by round-robin), its head instruction is loaded
//   into a registered issue slot with a valid/ready handshake, and a one-cycle
//   scoreboard/instruction-buffer pop pulse is produced for that warp.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   policy                0 = round-robin, 1 = greedy-then-round-robin
//   warp_ready            per-warp: instruction present and scoreboard clear
//   ib_instr/ib_unit      per-warp head instruction and unit code
//   ib_pc_wr/ib_pred_wr   per-warp head instruction writes PC / predicate
//   pred                  per-warp thread predicate mask
//   unit_ready            per-unit-class ready
//   sb_*                  registered issue pulse and destination decode
//   iss_*                 issue slot (valid/ready handshake to execution)
//   err                   [0] illegal unit code on a ready warp,
//                         [1] issued rd out of range
//   perf_issue            issues since reset (wraps)
//   perf_stall            cycles with eligible work but blocked slot (saturates)
// -----------------------------------------------------------------------------
module warp_issue_arbiter #(
  parameter int NUM_WARPS  = 32,
  parameter int WID_W      = $clog2(NUM_WARPS),
  parameter int INSTR_W    = 63,
  parameter int NUM_UNITS  = 3,
  parameter int UNIT_W     = 2,
  parameter int NUM_GPR    = 16,
  parameter int NUM_UNIR   = 8,
  parameter int GREEDY_MAX = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 policy,
  input  logic [NUM_WARPS-1:0]                 warp_ready,
  input  logic [NUM_WARPS-1:0][INSTR_W-1:0]    ib_instr,
  input  logic [NUM_WARPS-1:0][UNIT_W-1:0]     ib_unit,
  input  logic [NUM_WARPS-1:0]                 ib_pc_wr,
  input  logic [NUM_WARPS-1:0]                 ib_pred_wr,
  input  logic [NUM_WARPS-1:0][31:0]           pred,
  input  logic [NUM_UNITS-1:0]                 unit_ready,
  output logic                                 sb_valid,
  output logic [WID_W-1:0]                     sb_warp,
  output logic [4:0]                           sb_gpr,
  output logic [3:0]                           sb_unir,
  output logic                                 sb_is_pc,
  output logic                                 sb_is_pred,
  output logic                                 iss_valid,
  input  logic                                 iss_ready,
  output logic [WID_W-1:0]                     iss_warp,
  output logic [INSTR_W-1:0]                   iss_instr,
  output logic [31:0]                          iss_pred,
  output logic [NUM_UNITS-1:0]                 iss_unit,
  output logic [1:0]                           err,
  output logic [31:0]                          perf_issue,
  output logic [31:0]                          perf_stall
);

  localparam int                 BURST_W   = $clog2(GREEDY_MAX + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(GREEDY_MAX);
  localparam logic [5:0]         GPR_LIM   = 6'(NUM_GPR);
  localparam logic [5:0]         UNIR_LIM  = 6'(NUM_GPR + NUM_UNIR);

  // Unit code to one-hot unit-class vector; illegal codes map to all zeros.
  function automatic logic [NUM_UNITS-1:0] unit_onehot(input logic [UNIT_W-1:0] code);
    logic [NUM_UNITS-1:0] oh;
    oh = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      oh[u] = (code == UNIT_W'(u));
    end
    return oh;
  endfunction

  logic [WID_W-1:0]   last_idx_r;
  logic [BURST_W-1:0] burst_cnt_r;

  logic [NUM_WARPS-1:0] elig_s;
  logic                 bad_unit_s;
  logic [NUM_UNITS-1:0] oh_s;
  logic                 any_elig_s;
  logic                 fire_s;
  logic                 stall_s;
  logic                 greedy_s;
  logic                 found_s;
  logic [WID_W-1:0]     cand_s;
  logic [WID_W-1:0]     rr_sel_s;
  logic [WID_W-1:0]     sel_s;
  logic [INSTR_W-1:0]   sel_instr_s;
  logic [4:0]           rd_s;
  logic [2:0]           unir_idx_s;
  logic [4:0]           gpr_dec_s;
  logic [3:0]           unir_dec_s;
  logic                 rd_bad_s;

  // Eligibility: ready warp whose unit code is legal and whose unit accepts work.
  always_comb begin
    elig_s     = '0;
    bad_unit_s = 1'b0;
    oh_s       = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      oh_s       = unit_onehot(ib_unit[w]);
      elig_s[w]  = warp_ready[w] & (|(oh_s & unit_ready));
      bad_unit_s = bad_unit_s | (warp_ready[w] & ~(|oh_s));
    end
  end

  // Warp selection: greedy stays on last_idx under the burst cap, else RR scan.
  always_comb begin
    found_s  = 1'b0;
    cand_s   = last_idx_r;
    rr_sel_s = last_idx_r;
    // Scan starts at last_idx+1; the final candidate wraps back to last_idx itself.
    for (int i = 0; i < NUM_WARPS; i++) begin
      cand_s = last_idx_r + WID_W'(i + 1);
      if (!found_s && elig_s[cand_s]) begin
        rr_sel_s = cand_s;
        found_s  = 1'b1;
      end else begin
        found_s  = found_s;
      end
    end
    greedy_s = policy & elig_s[last_idx_r] & (burst_cnt_r < BURST_MAX);
    if (greedy_s) begin
      sel_s = last_idx_r;
    end else begin
      sel_s = rr_sel_s;
    end
  end

  // Fire/stall qualification and destination-register decode of the pick.
  always_comb begin
    any_elig_s  = |elig_s;
    fire_s      = any_elig_s & (~iss_valid | iss_ready);
    stall_s     = any_elig_s & iss_valid & ~iss_ready;
    sel_instr_s = ib_instr[sel_s];
    rd_s        = sel_instr_s[INSTR_W-1 -: 5];
    // Modular subtraction on the low bits yields rd-NUM_GPR within the UNIR window.
    unir_idx_s  = rd_s[2:0] - 3'(NUM_GPR);
    gpr_dec_s   = 5'd0;
    unir_dec_s  = 4'd0;
    if ({1'b0, rd_s} < GPR_LIM) begin
      gpr_dec_s = {1'b1, rd_s[3:0]};
    end else if ({1'b0, rd_s} < UNIR_LIM) begin
      unir_dec_s = {1'b1, unir_idx_s};
    end else begin
      gpr_dec_s  = 5'd0;
    end
    rd_bad_s = ({1'b0, rd_s} >= UNIR_LIM) & (rd_s != 5'd31);
  end

  // Issue slot: load on fire, empty when consumed without reload, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid <= 1'b0;
      iss_warp  <= '0;
      iss_instr <= '0;
      iss_pred  <= '0;
      iss_unit  <= '0;
    end else if (fire_s) begin
      iss_valid <= 1'b1;
      iss_warp  <= sel_s;
      iss_instr <= sel_instr_s;
      iss_pred  <= pred[sel_s];
      iss_unit  <= unit_onehot(ib_unit[sel_s]);
    end else if (iss_ready) begin
      iss_valid <= 1'b0;
    end else begin
      iss_valid <= iss_valid;
    end
  end

  // Scoreboard / buffer-pop pulse and error pulses, one cycle each.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_valid   <= 1'b0;
      sb_warp    <= '0;
      sb_gpr     <= 5'd0;
      sb_unir    <= 4'd0;
      sb_is_pc   <= 1'b0;
      sb_is_pred <= 1'b0;
      err        <= 2'b00;
    end else begin
      sb_valid   <= fire_s;
      sb_warp    <= fire_s ? sel_s : '0;
      sb_gpr     <= fire_s ? gpr_dec_s : 5'd0;
      sb_unir    <= fire_s ? unir_dec_s : 4'd0;
      sb_is_pc   <= fire_s & ib_pc_wr[sel_s];
      sb_is_pred <= fire_s & ib_pred_wr[sel_s];
      err        <= {fire_s & rd_bad_s, bad_unit_s};
    end
  end

  // Arbitration state: last issued warp and its consecutive-issue count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_idx_r  <= WID_W'(NUM_WARPS - 1);
      burst_cnt_r <= '0;
    end else if (fire_s) begin
      last_idx_r <= sel_s;
      if (sel_s == last_idx_r) begin
        burst_cnt_r <= (burst_cnt_r == BURST_MAX) ? burst_cnt_r : burst_cnt_r + BURST_W'(1);
      end else begin
        burst_cnt_r <= BURST_W'(1);
      end
    end else begin
      last_idx_r  <= last_idx_r;
      burst_cnt_r <= burst_cnt_r;
    end
  end

  // Performance counters: wrapping issue count, saturating stall count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue <= 32'd0;
      perf_stall <= 32'd0;
    end else begin
      perf_issue <= fire_s ? perf_issue + 32'd1 : perf_issue;
      if (stall_s && (perf_stall != 32'hFFFF_FFFF)) begin
        perf_stall <= perf_stall + 32'd1;
      end else begin
        perf_stall <= perf_stall;
      end
    end
  end

endmodule
